// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin arbiter sharing one combinational ALU between two
//            requesters. Each operation runs IDLE -> EXEC -> RESP.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
    parameter int DW  = 8,
    parameter int OPW = 4,
    parameter int CCW = 2
) (
    input  logic           clk,
    input  logic           rst,

    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [DW-1:0]  req0_a,
    input  logic [DW-1:0]  req0_b,
    input  logic [OPW-1:0] req0_op,

    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [DW-1:0]  req1_a,
    input  logic [DW-1:0]  req1_b,
    input  logic [OPW-1:0] req1_op,

    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [DW-1:0]  alu_e,
    input  logic [CCW-1:0] alu_cc,

    output logic           rsp_valid,
    output logic           rsp_id,
    output logic [DW-1:0]  rsp_e,
    output logic [CCW-1:0] rsp_cc,
    input  logic           rsp_ready,

    output logic [7:0]     done_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]     r_state;
    logic           r_rr_ptr;
    logic [DW-1:0]  r_alu_a;
    logic [DW-1:0]  r_alu_b;
    logic [OPW-1:0] r_alu_op;
    logic           r_rsp_id;
    logic [DW-1:0]  r_rsp_e;
    logic [CCW-1:0] r_rsp_cc;
    logic [7:0]     r_done_cnt;

    logic           w_in_idle;
    logic           w_gnt_id;
    logic           w_ready0;
    logic           w_ready1;
    logic           w_accept;

    assign w_in_idle = (r_state == S_IDLE);

    // Contention resolves to the round-robin pointer; otherwise the lone requester wins.
    assign w_gnt_id  = (req0_valid && req1_valid) ? r_rr_ptr : req1_valid;

    assign w_ready0  = !rst && w_in_idle && req0_valid && !w_gnt_id;
    assign w_ready1  = !rst && w_in_idle && req1_valid &&  w_gnt_id;
    assign w_accept  = w_ready0 || w_ready1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= 1'b0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_rsp_id   <= 1'b0;
            r_rsp_e    <= '0;
            r_rsp_cc   <= '0;
            r_done_cnt <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_alu_a  <= w_gnt_id ? req1_a  : req0_a;
                        r_alu_b  <= w_gnt_id ? req1_b  : req0_b;
                        r_alu_op <= w_gnt_id ? req1_op : req0_op;
                        r_rsp_id <= w_gnt_id;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_e  <= alu_e;
                    r_rsp_cc <= alu_cc;
                    r_state  <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_done_cnt <= r_done_cnt + 8'd1;
                        r_rr_ptr   <= ~r_rsp_id;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req0_ready = w_ready0;
    assign req1_ready = w_ready1;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_id     = r_rsp_id;
    assign rsp_e      = r_rsp_e;
    assign rsp_cc     = r_rsp_cc;
    assign done_cnt   = r_done_cnt;

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning operand/result width.
REQ-002 The block SHALL have parameter OPW, default 4, meaning ALU opcode width.
REQ-003 The block SHALL have parameter CCW, default 2, meaning condition-code width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req0_valid / req1_valid  input  1 each  requester i has an operation pending.
REQ-007 req0_ready / req1_ready  output  1 each  operation of requester i accepted this cycle.
REQ-008 req0_a, req0_b / req1_a, req1_b  input  DW each  operands of requester i.
REQ-009 req0_op / req1_op  input  OPW each  opcode of requester i.
REQ-010 alu_a, alu_b  output  DW each  registered operands to the shared ALU.
REQ-011 alu_op  output  OPW  registered opcode to the shared ALU.
REQ-012 alu_e  input  DW  combinational ALU result.
REQ-013 alu_cc  input  CCW  combinational ALU condition codes.
REQ-014 rsp_valid  output  1  response held valid.
REQ-015 rsp_id  output  1  requester owning the response (0 or 1).
REQ-016 rsp_e  output  DW  captured result; rsp_cc  output  CCW  captured condition codes.
REQ-017 rsp_ready  input  1  consumer takes the response this cycle.
REQ-018 done_cnt  output  8  count of completed responses.

Function
REQ-019 FSM states SHALL be IDLE, EXEC, RESP; encoding free.
REQ-020 In IDLE, grant SHALL go to the only valid requester; if both valid, to requester rr_ptr.
REQ-021 reqN_ready SHALL be combinational: high only in IDLE for the granted requester; both never high together.
REQ-022 Acceptance = reqN_valid && reqN_ready at a rising edge: latch that requester's a/b/op into alu_a/alu_b/alu_op, latch grant into rsp_id, go EXEC.
REQ-023 IDLE with no valid request SHALL stay IDLE; alu_* and rsp_* hold.
REQ-024 EXEC lasts exactly one cycle: at its closing edge, capture alu_e into rsp_e and alu_cc into rsp_cc, go RESP.
REQ-025 rsp_valid SHALL be high exactly while in RESP; rsp_id/rsp_e/rsp_cc stable throughout RESP.
REQ-026 Latency: acceptance at edge T gives rsp_valid high from edge T+2.
REQ-027 RESP with rsp_ready high at an edge: go IDLE, done_cnt += 1 (wraps 255 -> 0), rr_ptr <= ~rsp_id.
REQ-028 RESP with rsp_ready low SHALL hold RESP indefinitely; no new acceptance.
REQ-029 Requester inputs outside the acceptance edge SHALL be ignored; withdrawing valid before acceptance is legal.
REQ-030 rsp_ready outside RESP SHALL be ignored.
REQ-031 Throughput SHALL be at most one operation per 3 cycles (IDLE, EXEC, RESP each >= 1 cycle).

Reset
REQ-032 rst high at a rising edge SHALL force IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_e=0, rsp_cc=0, alu_a=alu_b=0, alu_op=0, done_cnt=0.
REQ-033 Reset in EXEC or RESP SHALL discard the in-flight operation; done_cnt not incremented.
REQ-034 While rst high, req0_ready and req1_ready SHALL be 0.

Verification
REQ-035 Single request: req0 a=8'h03 b=8'h02 op=0, rsp_ready=1 -> req0_ready at T, rsp_valid from T+2, rsp_id=0, rsp_e/rsp_cc equal ALU output for (3,2,0), done_cnt=1.
REQ-036 Contention: both valid continuously after reset, rsp_ready=1 -> grants 0,1,0,1 in order, one response per 3 cycles.
REQ-037 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_e stable 5 cycles, neither ready asserted, completes when rsp_ready=1.
REQ-038 Reset mid-op: rst during EXEC -> next cycle IDLE, rsp_valid=0, done_cnt unchanged at 0.
REQ-039 Wrap: 256 completed operations -> done_cnt reads 0, rr_ptr alternation unaffected.
REQ-040 Idle hold: no valid for 10 cycles after a response -> alu_a/alu_b/alu_op and rsp_* unchanged, rsp_valid=0.
